// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: multi-channel packet concentrator with per-channel FIFOs and a round-robin output arbiter.
//   clk, rst (async, active-high)
//   in_vld/in_rdy/in_addr/in_data : CH_NUM flattened input channels, channel i at [i*W +: W]
//   out_vld/out_rdy/out_addr/out_data/out_ch : single registered output with source channel index
//   PKT_MUX_STAT_EN defined : adds stat_clr input and stat_cnt (16-bit saturating push counter per channel)
module pkt_rr_mux #(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WD    = 7,
  parameter int DATA_WD    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM-1:0]            in_vld,
  output logic [CH_NUM-1:0]            in_rdy,
  input  logic [CH_NUM*ADDR_WD-1:0]    in_addr,
  input  logic [CH_NUM*DATA_WD-1:0]    in_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [ADDR_WD-1:0]           out_addr,
  output logic [DATA_WD-1:0]           out_data,
  output logic [$clog2(CH_NUM)-1:0]    out_ch
`ifdef PKT_MUX_STAT_EN
  ,
  input  logic                         stat_clr,
  output logic [CH_NUM*16-1:0]         stat_cnt
`endif
);
  localparam int CW = $clog2(CH_NUM);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int W  = ADDR_WD + DATA_WD;
  logic [CH_NUM-1:0] empty, push, pop;
  logic [W-1:0]      head [CH_NUM];
  logic [CW-1:0]     last_gnt, gnt, c;
  logic              gnt_vld, slot_free;
  assign slot_free = !out_vld || out_rdy;
  assign push      = in_vld & in_rdy;
  assign pop       = {{(CH_NUM-1){1'b0}}, slot_free && gnt_vld} << gnt;
  // Walk channels starting just after the last grant, wrapping at CH_NUM; first non-empty wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last_gnt;
    c       = last_gnt;
    for (int k = 0; k < CH_NUM; k++) begin
      c = (c == CW'(CH_NUM - 1)) ? '0 : c + 1'b1;
      if (!gnt_vld && !empty[c]) begin
        gnt_vld = 1'b1;
        gnt     = c;
      end
    end
  end
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    assign empty[i]  = cnt == '0;
    assign in_rdy[i] = cnt != (PW+1)'(FIFO_DEPTH);
    assign head[i]   = mem[rp];
    always_ff @(posedge clk)
      if (push[i]) mem[wp] <= {in_addr[i*ADDR_WD +: ADDR_WD], in_data[i*DATA_WD +: DATA_WD]};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        wp  <= wp + PW'(push[i]);
        rp  <= rp + PW'(pop[i]);
        cnt <= cnt + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      out_ch   <= '0;
      last_gnt <= CW'(CH_NUM - 1);
    end else if (slot_free) begin
      out_vld <= gnt_vld;
      if (gnt_vld) begin
        {out_addr, out_data} <= head[gnt];
        out_ch   <= gnt;
        last_gnt <= gnt;
      end
    end
`ifdef PKT_MUX_STAT_EN
  for (genvar i = 0; i < CH_NUM; i++) begin : g_stat
    logic [15:0] sc;
    assign stat_cnt[i*16 +: 16] = sc;
    always_ff @(posedge clk or posedge rst)
      if (rst) sc <= '0;
      else if (stat_clr) sc <= '0;
      else if (push[i] && sc != 16'hFFFF) sc <= sc + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pkt_rr_mux.sv
// tb_pkt_rr_mux: scoreboard bench for pkt_rr_mux with default parameters.
module tb_pkt_rr_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_vld, in_rdy;
  logic [27:0] in_addr;
  logic [127:0] in_data;
  logic        out_vld, out_rdy;
  logic [6:0]  out_addr;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
`ifdef PKT_MUX_STAT_EN
  logic        stat_clr;
  logic [63:0] stat_cnt;
`endif
  int checks = 0, failures = 0;
  typedef struct packed {logic [1:0] ch; logic [6:0] addr; logic [31:0] data;} pkt_t;
  pkt_t sb[$];
  pkt_t got, exp;

  pkt_rr_mux dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data), .out_ch(out_ch)
`ifdef PKT_MUX_STAT_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_ch(input int ch, input logic [6:0] a, input logic [31:0] d);
    in_addr[ch*7 +: 7]  = a;
    in_data[ch*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_vld = '0;
    out_rdy = 1'b0;
`ifdef PKT_MUX_STAT_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++;
    if (in_rdy !== 4'hF) begin failures++; $display("FAIL reset_in_rdy got=%h exp=f", in_rdy); end
    checks++;
    if ({out_ch, out_addr, out_data} !== '0) begin
      failures++; $display("FAIL reset_out_fields got=%h exp=0", {out_ch, out_addr, out_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    out_rdy = 1'b1;
    set_ch(2, 7'h15, 32'hDEADBEEF);
    in_vld = 4'b0100;
    if (in_rdy[2]) sb.push_back({2'd2, 7'h15, 32'hDEADBEEF});
    @(negedge clk);
    in_vld = '0;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", out_vld); end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b1) begin
      failures++; $display("FAIL single_vld got=%b exp=1", out_vld);
    end else if (sb.size() == 0) begin
      failures++; $display("FAIL single_sb_empty got=output exp=none");
    end else begin
      exp = sb.pop_front();
      got = {out_ch, out_addr, out_data};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL single_pkt got=%h exp=%h", got, exp); end
    end
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL single_vld_drop got=%b exp=0", out_vld); end
  endtask

  task automatic test_all_channels();
    int n = 0;
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 7'(c + 1), 32'h10 + c);
    in_vld = 4'hF;
    for (int c = 0; c < 4; c++) if (in_rdy[c]) sb.push_back({2'(c), 7'(c + 1), 32'h10 + c});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_vld = '0;
      checks++;
      if (out_vld !== (k >= 1 && k <= 4)) begin
        failures++; $display("FAIL all_vld_k%0d got=%b exp=%b", k, out_vld, (k >= 1 && k <= 4));
      end
      if (out_vld && out_rdy && sb.size() > 0) begin
        exp = sb.pop_front();
        got = {out_ch, out_addr, out_data};
        n++;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL all_pkt%0d got=%h exp=%h", n, got, exp); end
      end
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL all_count got=%0d exp=4", n); end
  endtask

  task automatic test_full();
    int acc = 0, n = 0;
    do_reset();
    out_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_ch(1, 7'(k), 32'h100 + k);
      in_vld = 4'b0010;
      if (in_rdy[1]) begin
        sb.push_back({2'd1, 7'(k), 32'h100 + k});
        acc++;
      end
      @(negedge clk);
    end
    in_vld = '0;
    checks++;
    if (acc != 5) begin failures++; $display("FAIL full_accepted got=%0d exp=5", acc); end
    checks++;
    if (in_rdy[1] !== 1'b0) begin failures++; $display("FAIL full_in_rdy got=%b exp=0", in_rdy[1]); end
    out_rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        checks++;
        if (in_rdy[1] !== 1'b1) begin failures++; $display("FAIL full_rdy_return got=%b exp=1", in_rdy[1]); end
      end
      if (out_vld && out_rdy) begin
        n++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL full_extra_out got=%0d exp=5", n);
        end else begin
          exp = sb.pop_front();
          got = {out_ch, out_addr, out_data};
          checks++;
          if (got !== exp) begin failures++; $display("FAIL full_pkt%0d got=%h exp=%h", n, got, exp); end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL full_out_count got=%0d exp=5", n); end
  endtask

  task automatic test_rr_fair();
    int kc0 = 0, kc3 = 0, e0 = 0, e3 = 0, n = 0;
    logic a0, a3;
    logic [1:0] ech;
    do_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_ch(0, 7'h00, 32'(kc0));
      set_ch(3, 7'h33, 32'h300 + kc3);
      in_vld = 4'b1001;
      a0 = in_rdy[0];
      a3 = in_rdy[3];
      if (out_vld && out_rdy && n < 8) begin
        ech = n[0] ? 2'd3 : 2'd0;
        checks++;
        if (out_ch !== ech) begin
          failures++; $display("FAIL rr_ch%0d got=%0d exp=%0d", n, out_ch, ech);
        end else begin
          got = {out_ch, out_addr, out_data};
          exp = (ech == 2'd0) ? {2'd0, 7'h00, 32'(e0)} : {2'd3, 7'h33, 32'h300 + e3};
          checks++;
          if (got !== exp) begin failures++; $display("FAIL rr_pkt%0d got=%h exp=%h", n, got, exp); end
          if (ech == 2'd0) e0++;
          else e3++;
        end
        n++;
      end
      @(negedge clk);
      if (a0) kc0++;
      if (a3) kc3++;
    end
    in_vld = '0;
    checks++;
    if (n != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", n); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ch(1, 7'h40 + 7'(k), 32'hA0 + k);
      in_vld = 4'b0010;
      @(negedge clk);
    end
    in_vld = '0;
    @(negedge clk);
    checks++;
    if (out_vld !== 1'b1) begin failures++; $display("FAIL mid_loaded got=%b exp=1", out_vld); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_async_vld got=%b exp=0", out_vld); end
    checks++;
    if (in_rdy !== 4'hF) begin failures++; $display("FAIL mid_in_rdy got=%h exp=f", in_rdy); end
    @(negedge clk);
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_vld !== 1'b0) begin failures++; $display("FAIL mid_stale_k%0d got=%b exp=0", k, out_vld); end
    end
  endtask

`ifdef PKT_MUX_STAT_EN
  task automatic test_stat();
    do_reset();
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 7'(k), 32'h500 + k);
      in_vld = 4'b0001;
      @(negedge clk);
    end
    in_vld = '0;
    checks++;
    if (stat_cnt[15:0] !== 16'd3) begin failures++; $display("FAIL stat_cnt0 got=%0d exp=3", stat_cnt[15:0]); end
    checks++;
    if (stat_cnt[31:16] !== 16'd0) begin failures++; $display("FAIL stat_cnt1 got=%0d exp=0", stat_cnt[31:16]); end
    stat_clr = 1'b1;
    in_vld = 4'b0001;
    @(negedge clk);
    stat_clr = 1'b0;
    in_vld = '0;
    checks++;
    if (stat_cnt[15:0] !== 16'd0) begin failures++; $display("FAIL stat_clr got=%0d exp=0", stat_cnt[15:0]); end
  endtask
`endif

  initial begin
    in_vld = '0;
    in_addr = '0;
    in_data = '0;
    out_rdy = 1'b0;
`ifdef PKT_MUX_STAT_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_all_channels();
    test_full();
    test_rr_fair();
    test_reset_mid();
`ifdef PKT_MUX_STAT_EN
    test_stat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pkt_rr_mux.md
Name: pkt_rr_mux

Overview:
- Multi-channel packet concentrator for the addr/data/vld packet bus, with a valid/ready handshake added on each side.
- CH_NUM independent input channels are each buffered in a small FIFO.
- A round-robin arbiter merges the channels onto one registered output carrying the source channel index.
- Sits between packet generators and a single downstream consumer; replaces point-to-point vld-only links.

Parameters:
- CH_NUM, 4, number of input channels (2..16)
- ADDR_WD, 7, packet address width
- DATA_WD, 32, packet data width
- FIFO_DEPTH, 4, entries per channel FIFO; power of 2, >=2

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_vld  input  CH_NUM  per-channel packet valid
- in_rdy  output  CH_NUM  per-channel ready (FIFO not full)
- in_addr  input  CH_NUM*ADDR_WD  flattened addresses; channel i at [i*ADDR_WD +: ADDR_WD]
- in_data  input  CH_NUM*DATA_WD  flattened data; channel i at [i*DATA_WD +: DATA_WD]
- out_vld  output  1  output packet valid
- out_rdy  input  1  downstream ready
- out_addr  output  ADDR_WD  output address
- out_data  output  DATA_WD  output data
- out_ch  output  $clog2(CH_NUM)  source channel of current output packet

Behaviour:
- Reset (async assert, sync release effect): all FIFO pointers and counts = 0; in_rdy = all ones; out_vld = 0; out_addr/out_data/out_ch = 0; last-grant pointer = CH_NUM-1, so ch0 has first priority.
- Input push: channel i pushes when in_vld[i] & in_rdy[i] at the clock edge.
- in_rdy[i] = !full[i], from registered count only. No combinational path from out_rdy.
- A full FIFO rejects a push even in a cycle where it pops.
- No bypass: a push into an empty FIFO is not visible to the arbiter until the next cycle.
- Output register "slot" is free when !out_vld | out_rdy.
- When the slot is free and at least one FIFO is non-empty, the arbiter grants the first non-empty channel searching from last_grant+1 upward, wrapping modulo CH_NUM.
- On a grant, in the same edge: pop the granted FIFO head; load out_addr/out_data; out_ch = granted index; out_vld = 1; last_grant = granted index.
- Slot free and all FIFOs empty: out_vld = 0 at the next edge. Data fields hold their last values (don't-care).
- While out_vld & !out_rdy, out_vld/out_addr/out_data/out_ch are stable.
- Latency: a packet accepted at edge N into an idle system gives out_vld = 1 after edge N+1.
- Sustained throughput: one packet per cycle with out_rdy held high.
- Per-channel ordering is preserved.
- Capacity per channel is FIFO_DEPTH + 1 with the output slot.
- Starvation-free: a non-empty channel is granted within CH_NUM grants.
- Pointer arithmetic: $clog2(FIFO_DEPTH) bits, natural wrap. Count is $clog2(FIFO_DEPTH)+1 bits.
- Reset mid-operation: all buffered packets are discarded and out_vld drops immediately (async).

Optional Feature:
- Macro: PKT_MUX_STAT_EN.
- Defined: adds output stat_cnt, width CH_NUM*16, flattened like in_addr.
- Per-channel 16-bit counter of accepted input pushes; saturates at 0xFFFF; reset to 0.
- Adds input stat_clr (1 bit): synchronous clear of all counters; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Idle system, single push ch2 addr=0x15 data=0xDEADBEEF, out_rdy=1 -> one cycle later out_vld=1, out_ch=2, addr 0x15, data 0xDEADBEEF; out_vld=0 the following cycle.
- All 4 channels push one packet in the same cycle (data=0x10+ch), out_rdy=1 -> outputs on 4 consecutive cycles, out_ch order 0,1,2,3.
- out_rdy=0, ch1 pushes continuously -> exactly 5 packets accepted, in_rdy[1]=0 from then on. With out_rdy=1, 5 outputs emerge in order, and in_rdy[1] returns high after the first pop.
- ch0 and ch3 continuously valid, out_rdy=1, 8 cycles -> out_ch sequence 0,3,0,3,0,3,0,3.
- Load 3 packets into ch1 with out_rdy=0, assert rst for 1 cycle -> out_vld=0 during reset, in_rdy all ones. No stale packet appears after release.
- PKT_MUX_STAT_EN: 3 pushes on ch0 -> stat_cnt[15:0]=3. Pulse stat_clr coincident with a push -> counter=0.
